mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator between the datapath's memory stage and the word-array data memory (`Data_Mem`). Accepts one byte-addressed request at a time (byte/half/word, signed or unsigned loads), converts it to a word index, drives the memory's port set, and returns load data or a completion pulse. Sub-word stores are done as read-modify-write because the memory has no byte enables. Misaligned and out-of-range requests are rejected without touching memory.

## Interface
- `WORD_BITS`, 10: word-index width; memory depth is 2^WORD_BITS words (1024).
- `Clock`  in  1  rising-edge clock shared with `Data_Mem`.
- `ResetN`  in  1  asynchronous, active-low reset.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  unit can accept; a request is taken on an edge where `ReqValid && ReqReady`.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqSize`  in  2  00 byte, 01 half, 10 word; 11 is an error.
- `ReqSigned`  in  1  sign-extend sub-word loads.
- `ReqAddr`  in  32  byte address.
- `ReqWData`  in  32  store data; byte/half taken from the low bits.
- `RespValid`  out  1  one-cycle completion pulse.
- `RespData`  out  32  extended load data; 0 for stores and errors.
- `RespError`  out  1  qualifies `RespValid`: request rejected.
- `MemAddress`  out  32  word index `{0, ReqAddr[WORD_BITS+1:2]}`.
- `MemWriteData`  out  32  word to write.
- `MemWriteEnable`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `MemReadData`  in  32  memory `ReadData`, registered by the memory at the edge ending a cycle with `MemWriteEnable = 0`.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- In IDLE, `ReqReady = 1`; in all other states it is 0. On acceptance, latch address, size, signedness, write flag, and data.
- Error check at acceptance (next state RESP with error set): size 11; half with `ReqAddr[0] = 1`; word with `ReqAddr[1:0] != 0`; or `ReqAddr[31:WORD_BITS+2] != 0`.
- Word store: IDLE → WR → RESP.
- Load: IDLE → RD → CAP → RESP.
- Sub-word store: IDLE → RD → CAP → WR → RESP.
- RD:
  - Drive `MemAddress`; `MemRead = 1`; `MemWriteEnable = 0`.
- CAP:
  - Sample `MemReadData`.
  - Load: select a lane. Byte k = bits [8k+7:8k], with k = `ReqAddr[1:0]`, little-endian. Half = bits [15:0] or [31:16] by `ReqAddr[1]`. Zero- or sign-extend, then register into `RespData`.
  - Sub-word store: merge the new byte/half into the sampled word and register it into `MemWriteData`.
- WR:
  - `MemWriteEnable = 1` for exactly one cycle with a stable address and data.
  - `MemRead = 0`.
- RESP:
  - `RespValid = 1` for one cycle; `RespError` as latched.
  - Next state IDLE.
  - The consumer must take the response; there is no back-pressure.
- `MemWriteEnable` and `MemRead` are never high together. Both are 0 in IDLE, RESP, and CAP.
- Errors never assert `MemWriteEnable` or `MemRead`.

## Timing
- Acceptance edge = E0.
- `RespValid` is high in the cycle after edge:
  - E1 for errors.
  - E2 for word stores.
  - E3 for loads.
  - E4 for sub-word stores.
- Back-to-back throughput: next acceptance at the edge ending RESP+1, i.e., the IDLE cycle.
- A store's write commits at the edge ending WR. A load issued immediately after sees the new data.
- Reset (`ResetN` low), asynchronous:
  - State IDLE.
  - `ReqReady`, `RespValid`, `RespError`, `MemWriteEnable`, and `MemRead` are 0.
  - `RespData`, `MemWriteData`, and `MemAddress` are 0.
  - `ReqReady` rises in the first cycle after release.
- Reset mid-operation abandons the request with no response. If asserted during WR, `MemWriteEnable` falls immediately, so no partial write occurs.

## Test plan
- Reset; word store `0xDEADBEEF` at 0x10 → `MemWriteEnable` high one cycle with `MemAddress` = 4; `RespValid` at E2; `RespError` 0.
- Word load at 0x10 → `MemRead` in RD with `MemAddress` = 4; `RespData` = `0xDEADBEEF` at E3.
- Byte load at 0x13:
  - signed → `0xFFFFFFDE`
  - unsigned → `0x000000DE`
- Half load at 0x12, signed → `0xFFFFDEAD`.
- Byte store `0x55` at 0x11 → RD/CAP/WR sequence; memory word 4 = `0xDEAD55EF`; `RespValid` at E4. A following word load returns `0xDEAD55EF`.
- Error cases, each giving `RespError` = 1 at E1 with no memory strobes:
  - word at 0x12
  - half at 0x11
  - size 11
  - address 0x1000
- `ResetN` pulsed low during WR of a sub-word store → `MemWriteEnable` drops asynchronously; word unchanged; no `RespValid`; `ReqReady` = 1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the memory stage and a
// word-array data memory (Data_Mem) that has no byte enables.
//
// One byte-addressed request is accepted at a time. Loads read the word,
// select the byte/half lane and zero/sign-extend it. Word stores write
// directly. Sub-word stores read the word, merge the new lane and write it
// back. Misaligned or out-of-range requests are rejected without any memory
// strobe.
//
// Ports
//   Clock, ResetN              clock (shared with Data_Mem), async active-low reset
//   ReqValid/ReqReady          request handshake (taken on ReqValid && ReqReady)
//   ReqWrite, ReqSize,
//   ReqSigned, ReqAddr,
//   ReqWData                   request fields (size 00 byte, 01 half, 10 word)
//   RespValid, RespData,
//   RespError                  one-cycle completion pulse, load data, reject flag
//   MemAddress, MemWriteData,
//   MemWriteEnable, MemRead    Data_Mem port set (MemAddress is a word index)
//   MemReadData                Data_Mem ReadData (registered by the memory)
module mem_access_unit #(
  parameter int WORD_BITS = 10
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWriteEnable,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        err_d;
  logic [31:0] widx_d;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of the store data onto the fetched word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] data);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[{lane, 3'b000} +: 8] = data[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = data[15:0];
    return r;
  endfunction

  // Reject bad size, misalignment, or any address bit above the memory depth.
  always_comb begin
    err_d = (ReqSize == 2'b11) ||
            (ReqSize == 2'b01 && ReqAddr[0]) ||
            (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00) ||
            ((ReqAddr >> (WORD_BITS + 2)) != 32'd0);
    widx_d = {{(32 - WORD_BITS){1'b0}}, ReqAddr[WORD_BITS+1:2]};
  end

  // All outputs are registered; strobes default low so each is a single-cycle
  // pulse unless a state explicitly raises it for the next cycle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q        <= S_IDLE;
      ReqReady       <= 1'b0;
      RespValid      <= 1'b0;
      RespError      <= 1'b0;
      RespData       <= 32'd0;
      MemAddress     <= 32'd0;
      MemWriteData   <= 32'd0;
      MemWriteEnable <= 1'b0;
      MemRead        <= 1'b0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      wdata_q        <= 32'd0;
    end else begin
      RespValid      <= 1'b0;
      RespError      <= 1'b0;
      MemWriteEnable <= 1'b0;
      MemRead        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Ready comes up one cycle after reset release and stays up in IDLE.
          ReqReady <= 1'b1;
          if (ReqValid && ReqReady) begin
            ReqReady <= 1'b0;
            write_q  <= ReqWrite;
            signed_q <= ReqSigned;
            size_q   <= ReqSize;
            lane_q   <= ReqAddr[1:0];
            wdata_q  <= ReqWData;
            RespData <= 32'd0;
            if (err_d) begin
              RespValid <= 1'b1;
              RespError <= 1'b1;
              state_q   <= S_RESP;
            end else begin
              MemAddress <= widx_d;
              if (ReqWrite && ReqSize == 2'b10) begin
                MemWriteData   <= ReqWData;
                MemWriteEnable <= 1'b1;
                state_q        <= S_WR;
              end else begin
                MemRead <= 1'b1;
                state_q <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          // Memory registers ReadData at the edge ending this cycle.
          state_q <= S_CAP;
        end
        S_CAP: begin
          if (write_q) begin
            MemWriteData   <= store_merge(MemReadData, size_q, lane_q, wdata_q);
            MemWriteEnable <= 1'b1;
            state_q        <= S_WR;
          end else begin
            RespData  <= load_extract(MemReadData, size_q, lane_q, signed_q);
            RespValid <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_WR: begin
          RespValid <= 1'b1;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          ReqReady <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
